flop_r: RTL and testbench



---
 rtl/flop_r.sv | 11 +
 tb/tb_flop_r.sv | 83 ++++++++
 2 files changed

// File: rtl/flop_r.sv
// flop_r: N-bit positive-edge register with synchronous active-high reset
module flop_r #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  always_ff @(posedge clk) q <= reset ? '0 : d;
endmodule

// File: tb/tb_flop_r.sv
// tb_flop_r: scoreboard bench for flop_r at N=64 and N=8
`timescale 1ns/10ps
module tb_flop_r;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] d;
  logic [63:0] q;
  logic [7:0]  d8;
  logic [7:0]  q8;
  logic [63:0] exp_q[$];
  logic [7:0]  exp8[$];
  int          n_checks = 0;
  int          n_fail = 0;

  flop_r #(.N(64)) dut (.clk(clk), .reset(reset), .d(d), .q(q));
  flop_r #(.N(8)) dut8 (.clk(clk), .reset(reset), .d(d8), .q(q8));

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, queue the expected result, compare just after the next rising edge
  task automatic cycle(input string tag, input logic r, input logic [63:0] v);
    logic [63:0] e;
    logic [7:0]  e8;
    @(negedge clk);
    reset = r;
    d = v;
    d8 = v[7:0];
    exp_q.push_back(r ? 64'h0 : v);
    exp8.push_back(r ? 8'h0 : v[7:0]);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    e8 = exp8.pop_front();
    check(tag, q, e);
    check({tag, "_n8"}, {56'h0, q8}, {56'h0, e8});
  endtask

  initial begin
    reset = 1'b1;
    d = '1;
    d8 = '1;
    cycle("reset0", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    cycle("reset1", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 10; i++) cycle($sformatf("seq%0d", i), 1'b0, 64'(i));
    cycle("load5", 1'b0, 64'd5);
    // q sits 1 ns after the edge here; wiggle d inside the high phase
    #4 d = 64'd7;
    #1 check("hold_hi", q, 64'd5);
    #3 d = 64'd5;
    #1 check("hold_restored", q, 64'd5);
    cycle("hold_edge", 1'b0, 64'd5);
    @(negedge clk);
    #2 d = 64'd7;
    #2 check("hold_lo", q, 64'd5);
    cycle("after_lo", 1'b0, 64'd5);
    cycle("dead_load", 1'b0, 64'hDEAD_BEEF_0000_0001);
    cycle("dead_reset", 1'b1, 64'hDEAD_BEEF_0000_0001);
    cycle("dead_release", 1'b0, 64'hDEAD_BEEF_0000_0001);
    cycle("load9", 1'b0, 64'd9);
    // Reset raised halfway through the low phase must wait for the edge
    @(negedge clk);
    #5 reset = 1'b1;
    #1 check("sync_before", q, 64'd9);
    @(posedge clk);
    #1 check("sync_after", q, 64'd0);
    check("sync_after_n8", {56'h0, q8}, 64'd0);
    cycle("reset_hold", 1'b1, 64'h1234_5678_9ABC_DEF0);
    cycle("full_width", 1'b0, 64'h8000_0000_0000_0001);
    cycle("n8_a5", 1'b0, 64'h0000_0000_0000_00A5);
    cycle("alt", 1'b0, 64'h5A5A_A5A5_0F0F_F0F0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
